mem_bus_bridge: RTL and testbench

- Sits between the multicycle CPU datapath's memory-address/data path and a variable-latency external memory.
- Accepts one word request at a time from the control unit.
- Runs a req/ack handshake with memory and stalls the control unit through `busy`.
- Returns read data, or flags misalignment/timeout through `cpu_err` so the control unit can vector to an exception handler.

---
 rtl/mem_bus_bridge_if.sv | 31 +++
 rtl/mem_bus_bridge.sv | 112 +++++++++++
 tb/tb_mem_bus_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_bridge_if.sv
// CPU-side and memory-side signal bundle for mem_bus_bridge.
// The bridge connects through the slave modport; the control unit and memory model use master.
interface mem_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_err, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_err, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// Single-word CPU-to-memory bridge: req/ack handshake, misalignment check and
// wait timeout, with a one-cycle ready/err completion pulse to the control unit.
module mem_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_bridge_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic misaligned, timed_out;
  assign misaligned = (bus.cpu_addr[1:0] != 2'b00);
  assign timed_out  = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.cpu_req) state_d = misaligned ? DONE : WAIT;
      WAIT:    if (bus.mem_ack || timed_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; ready/err only assert on entry to DONE.
  always_comb begin
    cnt_d   = cnt;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state)
      IDLE: if (bus.cpu_req) begin
        we_d    = bus.cpu_we;
        addr_d  = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        if (misaligned) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          req_d = 1'b1;
          cnt_d = '0;
        end
      end
      WAIT: begin
        // Ack takes priority over an expiring timeout in the same cycle.
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          if (!we_q) rdata_d = bus.mem_rdata;
        end else if (timed_out) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge with a completion scoreboard (TIMEOUT=4).
module tb_mem_bus_bridge;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ready_cnt = 0;
  rsp_t sb_q[$];

  mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    tick();
    bus.cpu_req   = 1'b0;
  endtask

  // Scoreboard: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (reset && bus.cpu_ready) begin
      ready_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("sb_err", 64'(bus.cpu_err), 64'(e.err));
        chk("sb_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    int rc;
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    #3;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_ready", 64'(bus.cpu_ready), 64'd0);
    chk("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    #19 reset = 1'b1;
    tick();

    // Read with three wait cycles.
    drive_req(1'b0, 32'h0000_0010, 32'h0);
    chk("rd_mem_req", 64'(bus.mem_req), 64'd1);
    chk("rd_mem_addr", 64'(bus.mem_addr), 64'h10);
    chk("rd_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rd_busy", 64'(bus.busy), 64'd1);
    sb_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
    repeat (3) begin
      tick();
      chk("rd_wait_ready", 64'(bus.cpu_ready), 64'd0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack   = 1'b0;
    chk("rd_ready", 64'(bus.cpu_ready), 64'd1);
    chk("rd_err", 64'(bus.cpu_err), 64'd0);
    chk("rd_rdata", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
    chk("rd_req_drop", 64'(bus.mem_req), 64'd0);
    tick();
    chk("rd_ready_once", 64'(bus.cpu_ready), 64'd0);
    chk("rd_idle", 64'(bus.busy), 64'd0);

    // Write with immediate ack: ready two cycles after accept.
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    drive_req(1'b1, 32'h0000_0020, 32'h1234_5678);
    chk("wr_mem_we", 64'(bus.mem_we), 64'd1);
    chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
    chk("wr_mem_req", 64'(bus.mem_req), 64'd1);
    chk("wr_not_ready_n1", 64'(bus.cpu_ready), 64'd0);
    sb_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
    tick();
    bus.mem_ack = 1'b0;
    chk("wr_ready", 64'(bus.cpu_ready), 64'd1);
    chk("wr_rdata_kept", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
    tick();

    // Misaligned read: error one cycle after accept, no memory request.
    drive_req(1'b0, 32'h0000_0013, 32'h0);
    sb_q.push_back('{err: 1'b1, rdata: 32'hDEAD_BEEF});
    chk("mis_ready", 64'(bus.cpu_ready), 64'd1);
    chk("mis_err", 64'(bus.cpu_err), 64'd1);
    chk("mis_mem_req", 64'(bus.mem_req), 64'd0);
    tick();
    chk("mis_idle", 64'(bus.busy), 64'd0);
    chk("mis_mem_req2", 64'(bus.mem_req), 64'd0);

    // Timeout: mem_req high for TIMEOUT+1 cycles, then error.
    drive_req(1'b0, 32'h0000_0040, 32'h0);
    sb_q.push_back('{err: 1'b1, rdata: 32'hDEAD_BEEF});
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_req_%0d", i), 64'(bus.mem_req), 64'd1);
      chk($sformatf("to_noready_%0d", i), 64'(bus.cpu_ready), 64'd0);
      tick();
    end
    chk("to_ready", 64'(bus.cpu_ready), 64'd1);
    chk("to_err", 64'(bus.cpu_err), 64'd1);
    chk("to_req_drop", 64'(bus.mem_req), 64'd0);
    chk("to_rdata_kept", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
    tick();

    // Ack on the counter==TIMEOUT cycle wins.
    drive_req(1'b0, 32'h0000_0044, 32'h0);
    sb_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    repeat (4) tick();
    chk("tie_req", 64'(bus.mem_req), 64'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack   = 1'b0;
    chk("tie_ready", 64'(bus.cpu_ready), 64'd1);
    chk("tie_err", 64'(bus.cpu_err), 64'd0);
    chk("tie_rdata", 64'(bus.cpu_rdata), 64'hCAFE_F00D);
    tick();

    // cpu_req held high with immediate acks: one accept per IDLE visit.
    rc = ready_cnt;
    repeat (3) sb_q.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h0000_0080;
    bus.cpu_wdata = 32'h0BAD_F00D;
    bus.mem_ack   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("hold_busy_%0d", i), 64'(bus.busy), 64'((i % 3) != 2));
      chk($sformatf("hold_ready_%0d", i), 64'(bus.cpu_ready), 64'((i % 3) == 1));
    end
    bus.cpu_req = 1'b0;
    #5;
    chk("hold_ready_count", 64'(ready_cnt - rc), 64'd3);
    tick();

    // Spurious ack while idle.
    rc = ready_cnt;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    repeat (3) begin
      tick();
      chk("spur_busy", 64'(bus.busy), 64'd0);
      chk("spur_mem_req", 64'(bus.mem_req), 64'd0);
    end
    bus.mem_ack = 1'b0;
    chk("spur_rdata", 64'(bus.cpu_rdata), 64'hCAFE_F00D);
    chk("spur_no_ready", 64'(ready_cnt - rc), 64'd0);

    // Reset asserted mid-WAIT.
    drive_req(1'b0, 32'h0000_0100, 32'h0);
    chk("rstw_req_before", 64'(bus.mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstw_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rstw_busy", 64'(bus.busy), 64'd0);
    chk("rstw_rdata", 64'(bus.cpu_rdata), 64'd0);
    #10 reset = 1'b1;
    rc = ready_cnt;
    repeat (10) tick();
    chk("rstw_no_ready", 64'(ready_cnt - rc), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
